mic_delay_align: RTL and testbench

- Upstream stage of the 16-input, 23-bit summing adder in the delay-and-sum beamformer.
- Accepts TDM-serialised 23-bit per-microphone samples, one channel per beat, channel 0 through 15 per frame.
- Stores each channel in its own circular history buffer.
- Once per completed frame, presents all 16 channels in parallel, each delayed by its own programmable whole-frame delay, ready for the adder's in0..in15.

---
 rtl/mic_delay_align.sv | 155 +++++++++++++++
 tb/tb_mic_delay_align.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_delay_align.sv
// Per-microphone delay alignment ahead of the 16-input beamformer adder.
// TDM beats fill per-channel history rings; each complete frame emits all channels delayed.
module mic_delay_align #(
    parameter int NCH   = 16,
    parameter int W     = 23,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [3:0]         in_ch,
    input  logic [W-1:0]       in_data,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_ch,
    input  logic [AW-1:0]      cfg_delay,
    output logic               out_valid,
    output logic [NCH*W-1:0]   out_data,
    output logic               frame_err
);

    typedef enum logic {
        SYNC,
        COLLECT
    } state_t;

    localparam logic [AW:0] FC_MAX = (AW+1)'(DEPTH);

    state_t          state;
    state_t          state_nx;
    logic [3:0]      expected;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   last_ptr;
    logic [AW:0]     frame_cnt;
    logic [AW-1:0]   pend_dly [NCH];
    logic [AW-1:0]   act_dly  [NCH];
    logic [W-1:0]    mem [NCH][DEPTH];

    logic            acc;
    logic            start;
    logic            done;
    logic            err;
    logic            rd_req;
    logic [AW-1:0]   rd_idx;
    logic [NCH*W-1:0] rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_nx;
        end
    end

    // Only the channel-sequence decision lives here; datapath follows the strobes.
    always_comb begin
        state_nx = state;
        acc      = 1'b0;
        start    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        if (in_valid) begin
            unique case (state)
                SYNC: begin
                    if (in_ch == 4'd0) begin
                        acc      = 1'b1;
                        start    = 1'b1;
                        state_nx = COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_ch == expected) begin
                        acc = 1'b1;
                        if (expected == 4'd15) begin
                            done     = 1'b1;
                            state_nx = SYNC;
                        end
                    end else begin
                        err = 1'b1;
                        if (in_ch == 4'd0) begin
                            acc   = 1'b1;
                            start = 1'b1;
                        end else begin
                            state_nx = SYNC;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected  <= '0;
            wr_ptr    <= '0;
            last_ptr  <= '0;
            frame_cnt <= '0;
            frame_err <= 1'b0;
            rd_req    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < NCH; k++) begin
                pend_dly[k] <= '0;
                act_dly[k]  <= '0;
            end
        end else begin
            frame_err <= err;
            rd_req    <= done;
            out_valid <= rd_req;
            if (rd_req) begin
                out_data <= rd_data;
            end
            if (start) begin
                expected <= 4'd1;
            end else if (acc) begin
                expected <= expected + 4'd1;
            end
            if (done) begin
                last_ptr <= wr_ptr;
                wr_ptr   <= wr_ptr + 1'b1;
                if (frame_cnt != FC_MAX) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            // Delays latch at frame start, so a same-edge write lands next frame.
            if (start) begin
                for (int k = 0; k < NCH; k++) begin
                    act_dly[k] <= pend_dly[k];
                end
            end
            if (cfg_we) begin
                pend_dly[cfg_ch] <= cfg_delay;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            mem[in_ch][wr_ptr] <= in_data;
        end
    end

    // Unfilled history reads as zero instead of stale memory.
    always_comb begin
        rd_data = '0;
        rd_idx  = '0;
        for (int k = 0; k < NCH; k++) begin
            rd_idx = last_ptr - act_dly[k];
            if ({1'b0, act_dly[k]} < frame_cnt) begin
                rd_data[k*W +: W] = mem[k][rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_mic_delay_align.sv
// Randomised and directed bench for mic_delay_align.
// A frame-level reference model predicts every output cycle.
module tb_mic_delay_align;

    localparam int NCH   = 16;
    localparam int W     = 23;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic [3:0]         in_ch = '0;
    logic [W-1:0]       in_data = '0;
    logic               cfg_we = 1'b0;
    logic [3:0]         cfg_ch = '0;
    logic [AW-1:0]      cfg_delay = '0;
    logic               out_valid;
    logic [NCH*W-1:0]   out_data;
    logic               frame_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mic_delay_align #(
        .NCH(NCH), .W(W), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ch(in_ch),
        .in_data(in_data),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_delay(cfg_delay),
        .out_valid(out_valid),
        .out_data(out_data),
        .frame_err(frame_err)
    );

    // Reference model: frame-level history per channel
    logic [W-1:0]     m_mem [NCH][DEPTH];
    int               m_pend [NCH];
    int               m_act  [NCH];
    int               m_wp, m_fc, m_exp;
    bit               m_sync;
    bit               m_d1, e_ov, e_err;
    logic [NCH*W-1:0] m_stage, e_data;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_sync = 1'b1; m_exp = 0; m_wp = 0; m_fc = 0;
                m_d1 = 1'b0; e_ov = 1'b0; e_err = 1'b0;
                e_data = '0; m_stage = '0;
                for (int k = 0; k < NCH; k++) begin
                    m_pend[k] = 0; m_act[k] = 0;
                end
            end else begin
                bit acc, start;
                int lp, idx;
                e_ov = m_d1;
                if (m_d1) e_data = m_stage;
                m_d1 = 1'b0;
                e_err = 1'b0;
                acc = 1'b0; start = 1'b0;
                if (in_valid) begin
                    if (m_sync) begin
                        if (in_ch == 0) begin acc = 1'b1; start = 1'b1; end
                    end else if (int'(in_ch) == m_exp) begin
                        acc = 1'b1;
                    end else begin
                        e_err = 1'b1;
                        if (in_ch == 0) begin acc = 1'b1; start = 1'b1; end
                        else m_sync = 1'b1;
                    end
                end
                if (start) begin
                    for (int k = 0; k < NCH; k++) m_act[k] = m_pend[k];
                    m_sync = 1'b0;
                end
                if (acc) begin
                    m_mem[in_ch][m_wp] = in_data;
                    m_exp = int'(in_ch) + 1;
                    if (in_ch == 15) begin
                        lp = m_wp;
                        m_wp = (m_wp + 1) % DEPTH;
                        if (m_fc < DEPTH) m_fc = m_fc + 1;
                        m_sync = 1'b1;
                        m_stage = '0;
                        for (int k = 0; k < NCH; k++) begin
                            idx = (lp - m_act[k]) & (DEPTH - 1);
                            if (m_act[k] < m_fc) m_stage[k*W +: W] = m_mem[k][idx];
                        end
                        m_d1 = 1'b1;
                    end
                end
                if (cfg_we) m_pend[cfg_ch] = int'(cfg_delay);
            end
        end
    end

    // Per-cycle comparison and output capture
    int ov_cnt  = 0;
    int err_cnt = 0;
    logic [NCH*W-1:0] out_log [$];

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (out_valid !== e_ov) begin
                failures++;
                $display("FAIL out_valid got=%0b exp=%0b t=%0t", out_valid, e_ov, $time);
            end
            checks++;
            if (frame_err !== e_err) begin
                failures++;
                $display("FAIL frame_err got=%0b exp=%0b t=%0t", frame_err, e_err, $time);
            end
            checks++;
            if (out_data !== e_data) begin
                failures++;
                $display("FAIL out_data got=%h exp=%h t=%0t", out_data, e_data, $time);
            end
            if (out_valid) begin
                ov_cnt++;
                out_log.push_back(out_data);
            end
            if (frame_err) err_cnt++;
        end
    end

    function automatic int lane(input logic [NCH*W-1:0] v, input int k);
        return int'(v[k*W +: W]);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic beat(input int ch, input int data);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_ch    = ch[3:0];
        in_data  = data[W-1:0];
        cfg_we   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            cfg_we   = 1'b0;
        end
    endtask

    task automatic frame(input int val, input bit inc);
        for (int k = 0; k < NCH; k++) beat(k, inc ? k + 1 : val);
    endtask

    task automatic set_cfg(input int ch, input int d);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        cfg_we    = 1'b1;
        cfg_ch    = ch[3:0];
        cfg_delay = d[AW-1:0];
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_out(input string name, input int target);
        int n = 0;
        while (ov_cnt < target && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (ov_cnt < target) begin
            failures++;
            $display("FAIL %s out_valid timeout got=%0d exp=%0d", name, ov_cnt, target);
        end
    endtask

    initial begin
        int b, e0, nxt;
        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL rst_out_data got=%h exp=0", out_data);
        end
        rst = 1'b0;

        // one frame, ch k = k+1
        b = ov_cnt;
        frame(0, 1'b1);
        idle(1);
        wait_out("t1", b + 1);
        for (int k = 0; k < NCH; k++) chk($sformatf("t1_ch%0d", k), lane(out_log[b], k), k + 1);

        // ch3 delay 2 over frames 1..5
        do_reset();
        set_cfg(3, 2);
        b = ov_cnt;
        for (int n = 1; n <= 5; n++) frame(n, 1'b0);
        idle(1);
        wait_out("t2", b + 5);
        for (int n = 1; n <= 5; n++) begin
            chk($sformatf("t2_f%0d_ch3", n), lane(out_log[b+n-1], 3), n <= 2 ? 0 : n - 2);
            chk($sformatf("t2_f%0d_ch0", n), lane(out_log[b+n-1], 0), n);
        end

        // broken sequence then recovery
        b = ov_cnt;
        e0 = err_cnt;
        beat(0, 7); beat(1, 7); beat(3, 7);
        idle(4);
        chk("t3_err_pulse", err_cnt, e0 + 1);
        chk("t3_no_ov", ov_cnt, b);
        frame(6, 1'b0);
        idle(1);
        wait_out("t3", b + 1);
        chk("t3_ch0", lane(out_log[b], 0), 6);
        chk("t3_ch3", lane(out_log[b], 3), 4);

        // mid-frame config waits for next frame
        do_reset();
        b = ov_cnt;
        for (int n = 1; n <= 3; n++) frame(n, 1'b0);
        for (int k = 0; k < NCH; k++) begin
            beat(k, 4);
            if (k == 7) begin
                cfg_we = 1'b1; cfg_ch = 4'd0; cfg_delay = 5'd1;
            end
        end
        frame(5, 1'b0);
        idle(1);
        wait_out("t4", b + 5);
        chk("t4_f4_ch0", lane(out_log[b+3], 0), 4);
        chk("t4_f5_ch0", lane(out_log[b+4], 0), 4);
        chk("t4_f5_ch1", lane(out_log[b+4], 1), 5);

        // all delays 31, back-to-back frames across wrap
        do_reset();
        for (int k = 0; k < NCH; k++) set_cfg(k, 31);
        b = ov_cnt;
        for (int n = 1; n <= 40; n++) frame(n, 1'b0);
        idle(1);
        wait_out("t5", b + 40);
        chk("t5_f1_ch0", lane(out_log[b], 0), 0);
        chk("t5_f31_ch9", lane(out_log[b+30], 9), 0);
        chk("t5_f32_ch5", lane(out_log[b+31], 5), 1);
        chk("t5_f40_ch0", lane(out_log[b+39], 0), 9);
        chk("t5_f40_ch15", lane(out_log[b+39], 15), 9);

        // reset mid-frame
        do_reset();
        set_cfg(2, 5);
        frame(1, 1'b0);
        frame(2, 1'b0);
        idle(1);
        for (int k = 0; k < 8; k++) beat(k, 3);
        idle(1);
        b = ov_cnt;
        do_reset();
        idle(4);
        chk("t6_no_ov", ov_cnt, b);
        frame(9, 1'b0);
        idle(1);
        wait_out("t6", b + 1);
        chk("t6_ch0", lane(out_log[b], 0), 9);
        chk("t6_ch2", lane(out_log[b], 2), 9);

        // randomised traffic
        do_reset();
        for (int k = 0; k < NCH; k++) set_cfg(k, int'($urandom_range(0, 31)));
        nxt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 29) == 0) in_ch = 4'($urandom_range(0, 15));
            else in_ch = nxt[3:0];
            in_data = W'($urandom);
            cfg_we = ($urandom_range(0, 39) == 0);
            cfg_ch = 4'($urandom_range(0, 15));
            cfg_delay = AW'($urandom_range(0, 31));
            if (in_valid) nxt = (int'(in_ch) + 1) % NCH;
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
